// File: rtl/regfile_mp.sv
// Multi-port register file with two byte-enabled write ports, an optional
// hardwired zero register, optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wa_en,
  input  logic [ADDR_W-1:0]       wa_addr,
  input  logic [DATA_W-1:0]       wa_data,
  input  logic [DATA_W/8-1:0]     wa_be,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic [DATA_W/8-1:0]     wb_be,
  input  logic                    sb_set_en,
  input  logic [ADDR_W-1:0]       sb_set_addr,
  output logic [DEPTH-1:0]        busy_vec
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  hit_a_s;
  logic [DEPTH-1:0]  hit_b_s;
  logic [DEPTH-1:0]  set_s;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  // Per-register decode of write and scoreboard-set targets; register 0 is
  // never a target when it is hardwired to zero.
  always_comb begin
    hit_a_s = '0;
    hit_b_s = '0;
    set_s   = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (ZERO_REG == 0 || r != 0) begin
        hit_a_s[r] = wa_en && (wa_addr == ADDR_W'(r));
        hit_b_s[r] = wb_en && (wb_addr == ADDR_W'(r));
        set_s[r]   = sb_set_en && (sb_set_addr == ADDR_W'(r));
      end else begin
        hit_a_s[r] = 1'b0;
        hit_b_s[r] = 1'b0;
        set_s[r]   = 1'b0;
      end
    end
  end

  // Next-state contents (port B wins per byte) and busy bits (set beats clear).
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
      for (int i = 0; i < NB; i++) begin
        if (hit_b_s[r] && wb_be[i]) begin
          mem_d[r][8*i +: 8] = wb_data[8*i +: 8];
        end else if (hit_a_s[r] && wa_be[i]) begin
          mem_d[r][8*i +: 8] = wa_data[8*i +: 8];
        end else begin
          mem_d[r][8*i +: 8] = mem_q[r][8*i +: 8];
        end
      end
      if (set_s[r]) begin
        busy_d[r] = 1'b1;
      end else if (hit_a_s[r] || hit_b_s[r]) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports; the bypassed value is exactly the post-edge contents.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (rst) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if (!addr_in_range(ra) || (ZERO_REG != 0 && ra == ADDR_W'(0))) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if (BYPASS != 0) begin
        rd_data[k*DATA_W +: DATA_W] = mem_d[ra];
        rd_busy[k]                  = busy_q[ra] & ~(hit_a_s[ra] | hit_b_s[ra]);
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
        rd_busy[k]                  = busy_q[ra];
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero reg + bypass, and plain with a
// shallow depth) share stimulus and are checked against an array-based model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wa_en, wb_en, sb_set_en;
  logic [4:0]  wa_addr, wb_addr, sb_set_addr;
  logic [31:0] wa_data, wb_data;
  logic [3:0]  wa_be, wb_be;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [31:0] busy_vec0;
  logic [23:0] busy_vec1;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] m0 [32];
  logic [31:0] m1 [24];
  logic [31:0] bv0;
  logic [23:0] bv1;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_be(wa_be),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec0));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .NRD(2), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_be(wa_be),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec1));

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic writes_to(input int a);
    return (wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a);
  endfunction

  // Value register a holds after the coming edge: apply A, then B on top.
  function automatic logic [31:0] post_val(input int cfg, input int a);
    logic [31:0] v;
    if (cfg == 0) begin
      if (a == 0) return 32'h0;
      v = m0[a];
    end else begin
      if (a >= 24) return 32'h0;
      v = m1[a];
    end
    if (wa_en && int'(wa_addr) == a) v = merge(v, wa_data, wa_be);
    if (wb_en && int'(wb_addr) == a) v = merge(v, wb_data, wb_be);
    return v;
  endfunction

  function automatic logic post_busy(input int cfg, input int a);
    logic b;
    if (cfg == 0) begin
      if (a == 0) return 1'b0;
      b = bv0[a];
    end else begin
      if (a >= 24) return 1'b0;
      b = bv1[a];
    end
    if (writes_to(a)) b = 1'b0;
    if (sb_set_en && int'(sb_set_addr) == a) b = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_rd(input int cfg, input int a);
    if (rst) return 32'h0;
    if (cfg == 0) return post_val(0, a);
    return (a >= 24) ? 32'h0 : m1[a];
  endfunction

  function automatic logic exp_busy(input int cfg, input int a);
    if (rst) return 1'b0;
    if (cfg == 0) return (a == 0) ? 1'b0 : (bv0[a] & ~writes_to(a));
    return (a >= 24) ? 1'b0 : bv1[a];
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 32; a++) m0[a] = 32'h0;
    for (int a = 0; a < 24; a++) m1[a] = 32'h0;
    bv0 = 32'h0;
    bv1 = 24'h0;
  endtask

  task automatic tick();
    logic [31:0] n0 [32];
    logic [31:0] n1 [24];
    logic [31:0] nb0;
    logic [23:0] nb1;
    for (int a = 0; a < 32; a++) begin
      n0[a] = post_val(0, a);
      nb0[a] = post_busy(0, a);
    end
    for (int a = 0; a < 24; a++) begin
      n1[a] = post_val(1, a);
      nb1[a] = post_busy(1, a);
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int a = 0; a < 32; a++) m0[a] = n0[a];
      for (int a = 0; a < 24; a++) m1[a] = n1[a];
      bv0 = nb0;
      bv1 = nb1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wa_en = 1'b0; wa_addr = 5'd0; wa_data = 32'h0; wa_be = 4'h0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; wb_be = 4'h0;
    sb_set_en = 1'b0; sb_set_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hCAFEF00D; wa_be = 4'hF;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55AA55AA; wb_be = 4'hF;
    sb_set_en = 1'b1; sb_set_addr = 5'd5;
    rd_addr = {5'd4, 5'd3};
    repeat (2) @(posedge clk);
    #2;
    chk_cnt++;
    if (rd_data0 !== 64'h0) $display("FAIL reset_rd_data0 got=%h exp=0", rd_data0);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data1 !== 64'h0) $display("FAIL reset_rd_data1 got=%h exp=0", rd_data1);
    else pass_cnt++;
    chk_cnt++;
    if ({rd_busy0, rd_busy1} !== 4'h0) $display("FAIL reset_rd_busy got=%b%b exp=0", rd_busy0, rd_busy1);
    else pass_cnt++;
    chk_cnt++;
    if (busy_vec0 !== 32'h0 || busy_vec1 !== 24'h0)
      $display("FAIL reset_busy_vec got=%h/%h exp=0", busy_vec0, busy_vec1);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEADBEEF; wa_be = 4'hF;
    tick();
    idle_inputs();
    rd_addr = {5'd3, 5'd3};
    #1;
    chk_cnt++;
    if (rd_data0[31:0] !== 32'hDEADBEEF) $display("FAIL reset_first_write0 got=%h exp=deadbeef", rd_data0[31:0]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data1[63:32] !== 32'hDEADBEEF) $display("FAIL reset_first_write1 got=%h exp=deadbeef", rd_data1[63:32]);
    else pass_cnt++;
  endtask

  task automatic test_byte_merge();
    idle_inputs();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h11223344; wa_be = 4'hF;
    tick();
    wa_data = 32'hAAAAAAAA; wa_be = 4'b0011;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hBBBBBBBB; wb_be = 4'b0110;
    rd_addr = {5'd5, 5'd5};
    #1;
    chk_cnt++;
    if (rd_data0 !== {2{32'h11BBBBAA}}) $display("FAIL merge_bypass got=%h exp=11bbbbaa x2", rd_data0);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data1[31:0] !== 32'h11223344) $display("FAIL merge_no_bypass got=%h exp=11223344", rd_data1[31:0]);
    else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (rd_data0[31:0] !== 32'h11BBBBAA || rd_data1[31:0] !== 32'h11BBBBAA)
      $display("FAIL merge_stored got=%h/%h exp=11bbbbaa", rd_data0[31:0], rd_data1[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF; wa_be = 4'hF;
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    chk_cnt++;
    if (rd_data0 !== 64'h0 || rd_busy0 !== 2'b00) $display("FAIL zero_bypass got=%h/%b exp=0/00", rd_data0, rd_busy0);
    else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (rd_data0[31:0] !== 32'h0 || busy_vec0[0] !== 1'b0)
      $display("FAIL zero_reg got=%h/%b exp=0/0", rd_data0[31:0], busy_vec0[0]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data1[31:0] !== 32'hFFFFFFFF || busy_vec1[0] !== 1'b1)
      $display("FAIL zero_off got=%h/%b exp=ffffffff/1", rd_data1[31:0], busy_vec1[0]);
    else pass_cnt++;
  endtask

  task automatic test_bypass_off();
    logic [31:0] old;
    old = m1[7];
    idle_inputs();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h12345678; wa_be = 4'hF;
    rd_addr = {5'd7, 5'd7};
    #1;
    chk_cnt++;
    if (rd_data1 !== {2{old}}) $display("FAIL bypass_off_old got=%h exp=%h x2", rd_data1, old);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data0[31:0] !== 32'h12345678) $display("FAIL bypass_on_new got=%h exp=12345678", rd_data0[31:0]);
    else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (rd_data1[31:0] !== 32'h12345678) $display("FAIL bypass_off_next got=%h exp=12345678", rd_data1[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (busy_vec0[9] !== 1'b1 || busy_vec1[9] !== 1'b1)
      $display("FAIL sb_set got=%b/%b exp=1/1", busy_vec0[9], busy_vec1[9]);
    else pass_cnt++;
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = $urandom; wa_be = 4'h0;
    rd_addr = {5'd9, 5'd9};
    #1;
    chk_cnt++;
    if (rd_busy0 !== 2'b00 || rd_busy1 !== 2'b11)
      $display("FAIL sb_clear_fwd got=%b/%b exp=00/11", rd_busy0, rd_busy1);
    else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (busy_vec0[9] !== 1'b0 || busy_vec1[9] !== 1'b0)
      $display("FAIL sb_clear got=%b/%b exp=0/0", busy_vec0[9], busy_vec1[9]);
    else pass_cnt++;
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9; wb_be = 4'hF;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (busy_vec0[9] !== 1'b1) $display("FAIL sb_set_wins got=%b exp=1", busy_vec0[9]);
    else pass_cnt++;
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    tick();
    idle_inputs();
    wa_en = 1'b1; wa_addr = 5'd9; wa_be = 4'hF; wa_data = 32'h99;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (busy_vec0[9] !== 1'b0) $display("FAIL sb_no_count got=%b exp=0", busy_vec0[9]);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [23:0] bv1_before;
    bv1_before = busy_vec1;
    idle_inputs();
    wa_en = 1'b1; wa_addr = 5'd30; wa_data = 32'hFFFFFFFF; wa_be = 4'hF;
    sb_set_en = 1'b1; sb_set_addr = 5'd30;
    rd_addr = {5'd30, 5'd30};
    #1;
    chk_cnt++;
    if (rd_data1 !== 64'h0 || rd_busy1 !== 2'b00) $display("FAIL oor_read got=%h/%b exp=0/00", rd_data1, rd_busy1);
    else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    chk_cnt++;
    if (busy_vec1 !== bv1_before || rd_data1 !== 64'h0)
      $display("FAIL oor_ignored got=%h/%h exp=%h/0", busy_vec1, rd_data1, bv1_before);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data0[31:0] !== 32'hFFFFFFFF || busy_vec0[30] !== 1'b1)
      $display("FAIL oor_full_depth got=%h/%b exp=ffffffff/1", rd_data0[31:0], busy_vec0[30]);
    else pass_cnt++;
  endtask

  function automatic logic [4:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 9));
  endfunction

  task automatic test_random();
    int a;
    logic [4:0] ra [2];
    for (int cyc = 0; cyc < 300; cyc++) begin
      wa_en = 1'($urandom_range(0, 1)); wa_addr = pick_addr(); wa_data = $urandom; wa_be = 4'($urandom_range(0, 15));
      wb_en = 1'($urandom_range(0, 1)); wb_addr = pick_addr(); wb_data = $urandom; wb_be = 4'($urandom_range(0, 15));
      sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = pick_addr();
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 2))
          0: ra[k] = wa_addr;
          1: ra[k] = wb_addr;
          default: ra[k] = pick_addr();
        endcase
      end
      rd_addr = {ra[1], ra[0]};
      #1;
      for (int k = 0; k < 2; k++) begin
        a = int'(ra[k]);
        chk_cnt++;
        if (rd_data0[32*k +: 32] !== exp_rd(0, a))
          $display("FAIL rand_data0 cyc=%0d port=%0d addr=%0d got=%h exp=%h", cyc, k, a, rd_data0[32*k +: 32], exp_rd(0, a));
        else pass_cnt++;
        chk_cnt++;
        if (rd_busy0[k] !== exp_busy(0, a))
          $display("FAIL rand_busy0 cyc=%0d port=%0d addr=%0d got=%b exp=%b", cyc, k, a, rd_busy0[k], exp_busy(0, a));
        else pass_cnt++;
        chk_cnt++;
        if (rd_data1[32*k +: 32] !== exp_rd(1, a))
          $display("FAIL rand_data1 cyc=%0d port=%0d addr=%0d got=%h exp=%h", cyc, k, a, rd_data1[32*k +: 32], exp_rd(1, a));
        else pass_cnt++;
        chk_cnt++;
        if (rd_busy1[k] !== exp_busy(1, a))
          $display("FAIL rand_busy1 cyc=%0d port=%0d addr=%0d got=%b exp=%b", cyc, k, a, rd_busy1[k], exp_busy(1, a));
        else pass_cnt++;
      end
      chk_cnt++;
      if (busy_vec0 !== bv0 || busy_vec1 !== bv1)
        $display("FAIL rand_busy_vec cyc=%0d got=%h/%h exp=%h/%h", cyc, busy_vec0, busy_vec1, bv0, bv1);
      else pass_cnt++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    logic [4:0] addrs [8];
    addrs = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      wa_en = 1'b1; wa_addr = addrs[i]; wa_data = $urandom | 32'h1; wa_be = 4'hF;
      sb_set_en = 1'b1; sb_set_addr = addrs[i];
      tick();
    end
    idle_inputs();
    rd_addr = {5'd12, 5'd4};
    #1;
    chk_cnt++;
    if (busy_vec0 !== 32'h0000F0F0 || busy_vec1 !== 24'h00F0F0)
      $display("FAIL async_setup got=%h/%h exp=0000f0f0/00f0f0", busy_vec0, busy_vec1);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data0[31:0] !== m0[4] || rd_data0[31:0] === 32'h0)
      $display("FAIL async_setup_data got=%h exp=%h", rd_data0[31:0], m0[4]);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (rd_data0 !== 64'h0 || rd_data1 !== 64'h0 || rd_busy0 !== 2'b00 || rd_busy1 !== 2'b00)
      $display("FAIL async_rd got=%h/%h/%b/%b exp=0", rd_data0, rd_data1, rd_busy0, rd_busy1);
    else pass_cnt++;
    chk_cnt++;
    if (busy_vec0 !== 32'h0 || busy_vec1 !== 24'h0)
      $display("FAIL async_busy got=%h/%h exp=0", busy_vec0, busy_vec1);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    chk_cnt++;
    if (rd_data0 !== 64'h0 || rd_data1 !== 64'h0)
      $display("FAIL async_cleared got=%h/%h exp=0", rd_data0, rd_data1);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = 10'd0;
    idle_inputs();
    test_reset();
    test_byte_merge();
    test_zero_reg();
    test_bypass_off();
    test_scoreboard();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
